// File: rtl/mem_stage.sv
// MEM pipeline stage: decodes loads/stores, runs a two-state handshake with the
// data memory, and registers the M/W pipeline outputs for the writeback stage.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_PC,
  input  logic [31:0] M_ins,
  input  logic [31:0] alu_res,
  input  logic [31:0] reg_rt,
  output logic        m_stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic [31:0] W_PC,
  output logic [31:0] W_ins,
  output logic [31:0] W_alu_res,
  output logic [31:0] W_mem_read,
  output logic        misalign
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;

  logic [0:0]  state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ins_q, ins_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] w_pc_q, w_pc_d;
  logic [31:0] w_ins_q, w_ins_d;
  logic [31:0] w_alu_q, w_alu_d;
  logic [31:0] w_mem_q, w_mem_d;
  logic        misalign_q, misalign_d;

  // Decode of the instruction currently presented by the M stage
  logic [5:0]  opcode;
  logic        is_load, is_store, is_mem, bad_align;
  logic [3:0]  new_be;
  logic [31:0] new_wdata;

  assign opcode = M_ins[31:26];

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    bad_align = 1'b0;
    new_be    = 4'b1111;
    new_wdata = reg_rt;
    case (opcode)
      OP_LW: begin
        is_load   = 1'b1;
        bad_align = (alu_res[1:0] != 2'b00);
      end
      OP_LH, OP_LHU: begin
        is_load   = 1'b1;
        bad_align = alu_res[0];
      end
      OP_LB, OP_LBU: begin
        is_load   = 1'b1;
      end
      OP_SW: begin
        is_store  = 1'b1;
        bad_align = (alu_res[1:0] != 2'b00);
      end
      OP_SH: begin
        is_store  = 1'b1;
        bad_align = alu_res[0];
        new_be    = alu_res[1] ? 4'b1100 : 4'b0011;
        new_wdata = {2{reg_rt[15:0]}};
      end
      OP_SB: begin
        is_store  = 1'b1;
        new_be    = 4'b0001 << alu_res[1:0];
        new_wdata = {4{reg_rt[7:0]}};
      end
      default: ;
    endcase
    is_mem = is_load | is_store;
  end

  // Load extraction works off the latched op/address, never the live M inputs
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  always_comb begin
    case (addr_q[1:0])
      2'd0:    sel_byte = dm_rdata[7:0];
      2'd1:    sel_byte = dm_rdata[15:8];
      2'd2:    sel_byte = dm_rdata[23:16];
      default: sel_byte = dm_rdata[31:24];
    endcase
    sel_half = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (op_q)
      OP_LW:   load_data = dm_rdata;
      OP_LH:   load_data = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  load_data = {16'h0000, sel_half};
      OP_LB:   load_data = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  load_data = {24'h000000, sel_byte};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    pc_d       = pc_q;
    ins_d      = ins_q;
    alu_d      = alu_q;
    w_pc_d     = 32'h0;
    w_ins_d    = 32'h0;
    w_alu_d    = 32'h0;
    w_mem_d    = 32'h0;
    misalign_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem && !bad_align) begin
          state_d = S_BUSY;
          op_d    = opcode;
          addr_d  = alu_res;
          be_d    = new_be;
          wdata_d = new_wdata;
          we_d    = is_store;
          pc_d    = M_PC;
          ins_d   = M_ins;
          alu_d   = alu_res;
        end else if (is_mem) begin
          misalign_d = 1'b1;
        end else begin
          w_pc_d  = M_PC;
          w_ins_d = M_ins;
          w_alu_d = alu_res;
        end
      end
      default: begin
        if (dm_ack) begin
          state_d = S_IDLE;
          w_pc_d  = pc_q;
          w_ins_d = ins_q;
          w_alu_d = alu_q;
          w_mem_d = load_data;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 6'h0;
      addr_q     <= 32'h0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      we_q       <= 1'b0;
      pc_q       <= 32'h0;
      ins_q      <= 32'h0;
      alu_q      <= 32'h0;
      w_pc_q     <= 32'h0;
      w_ins_q    <= 32'h0;
      w_alu_q    <= 32'h0;
      w_mem_q    <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      pc_q       <= pc_d;
      ins_q      <= ins_d;
      alu_q      <= alu_d;
      w_pc_q     <= w_pc_d;
      w_ins_q    <= w_ins_d;
      w_alu_q    <= w_alu_d;
      w_mem_q    <= w_mem_d;
      misalign_q <= misalign_d;
    end
  end

  // Request strobes are gated by the state so IDLE always shows them low
  assign dm_req   = (state_q == S_BUSY);
  assign dm_we    = dm_req & we_q;
  assign dm_be    = dm_req ? be_q : 4'h0;
  assign dm_addr  = {addr_q[31:2], 2'b00};
  assign dm_wdata = wdata_q;

  assign m_stall = !reset && (((state_q == S_IDLE) && is_mem && !bad_align) ||
                              ((state_q == S_BUSY) && !dm_ack));

  assign W_PC       = w_pc_q;
  assign W_ins      = w_ins_q;
  assign W_alu_res  = w_alu_q;
  assign W_mem_read = w_mem_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed loads/stores against a scripted memory, with a
// scoreboard queue holding the expected W-stage record of every instruction.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] M_PC, M_ins, alu_res, reg_rt;
  logic        m_stall, dm_req, dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ack;
  logic [31:0] W_PC, W_ins, W_alu_res, W_mem_read;
  logic        misalign;

  int checks = 0;
  int errors = 0;
  logic [127:0] sb_q[$];

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .M_PC(M_PC), .M_ins(M_ins), .alu_res(alu_res), .reg_rt(reg_rt),
    .m_stall(m_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .W_PC(W_PC), .W_ins(W_ins), .W_alu_res(W_alu_res), .W_mem_read(W_mem_read),
    .misalign(misalign)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard: any non-bubble W record (PCs used are nonzero) is popped and compared
  always @(negedge clk) begin
    if (reset === 1'b0 && W_PC !== 32'h0) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_W", W_PC, 32'h0);
      end else begin
        logic [127:0] e;
        e = sb_q.pop_front();
        check("W_PC", W_PC, e[127:96]);
        check("W_ins", W_ins, e[95:64]);
        check("W_alu_res", W_alu_res, e[63:32]);
        check("W_mem_read", W_mem_read, e[31:0]);
        $display("W pc=0x%08h ins=0x%08h alu=0x%08h rd=0x%08h", W_PC, W_ins, W_alu_res, W_mem_read);
      end
    end
  end

  task automatic filler();
    @(negedge clk);
    M_PC = 32'h0; M_ins = 32'h0; alu_res = 32'h0; reg_rt = 32'h0; dm_ack = 1'b0;
  endtask

  task automatic alu_op(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] alu);
    @(negedge clk);
    M_PC = pc; M_ins = ins; alu_res = alu; reg_rt = 32'h0; dm_ack = 1'b0;
    sb_q.push_back({pc, ins, alu, 32'h0});
    #1;
    check("alu_m_stall", {31'h0, m_stall}, 32'h0);
    check("alu_dm_req", {31'h0, dm_req}, 32'h0);
  endtask

  task automatic mem_op(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] addr,
                        input logic [31:0] rt, input logic [31:0] rdata, input int wait_cyc,
                        input logic exp_we, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rd);
    logic [31:0] ins;
    int stalls;
    ins = {op, 5'd4, 5'd5, 16'h0010};
    stalls = 0;
    @(negedge clk);
    M_PC = pc; M_ins = ins; alu_res = addr; reg_rt = rt; dm_ack = 1'b0;
    sb_q.push_back({pc, ins, addr, exp_rd});
    #1;
    check("acc_dm_req_idle", {31'h0, dm_req}, 32'h0);
    if (m_stall) stalls++;
    for (int i = 0; i <= wait_cyc; i++) begin
      @(negedge clk);
      if (i == 0) begin
        // Upstream disturbance during BUSY must not leak into the request
        M_PC = 32'hDEAD0000; M_ins = {6'h2B, 26'h0}; alu_res = 32'hFFFF_FFF1; reg_rt = 32'h0BAD_F00D;
      end
      dm_ack = (i == wait_cyc);
      dm_rdata = (i == wait_cyc) ? rdata : 32'hA5A5_5A5A;
      #1;
      check("busy_dm_req", {31'h0, dm_req}, 32'h1);
      check("busy_dm_we", {31'h0, dm_we}, {31'h0, exp_we});
      check("busy_dm_be", {28'h0, dm_be}, {28'h0, exp_be});
      check("busy_dm_addr", dm_addr, {addr[31:2], 2'b00});
      if (exp_we) check("busy_dm_wdata", dm_wdata, exp_wdata);
      check("busy_W_bubble", W_PC | W_ins | W_alu_res | W_mem_read, 32'h0);
      if (m_stall) stalls++;
    end
    check("stall_cycles", stalls, wait_cyc + 1);
    $display("mem op=0x%02h addr=0x%08h be=%b we=%0d stalls=%0d", op, addr, dm_be, dm_we, stalls);
  endtask

  task automatic misalign_op(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] addr);
    @(negedge clk);
    M_PC = pc; M_ins = {op, 26'h0}; alu_res = addr; reg_rt = 32'h1111_2222; dm_ack = 1'b0;
    #1;
    check("mis_m_stall", {31'h0, m_stall}, 32'h0);
    check("mis_dm_req", {31'h0, dm_req}, 32'h0);
    @(negedge clk);
    check("mis_pulse", {31'h0, misalign}, 32'h1);
    check("mis_W_bubble", W_PC | W_ins | W_alu_res | W_mem_read, 32'h0);
    M_PC = 32'h0; M_ins = 32'h0; alu_res = 32'h0; dm_ack = 1'b1;  // stray ack in IDLE
    #1;
    check("stray_ack_req", {31'h0, dm_req}, 32'h0);
    @(negedge clk);
    dm_ack = 1'b0;
    check("mis_pulse_end", {31'h0, misalign}, 32'h0);
    check("stray_ack_W", W_PC | W_mem_read, 32'h0);
    $display("misaligned op=0x%02h addr=0x%08h dropped", op, addr);
  endtask

  initial begin
    reset = 1'b1; M_PC = 0; M_ins = {6'h23, 26'h0}; alu_res = 0; reg_rt = 0;
    dm_rdata = 0; dm_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_m_stall", {31'h0, m_stall}, 32'h0);
    check("rst_dm_req", {31'h0, dm_req}, 32'h0);
    check("rst_dm_we", {31'h0, dm_we}, 32'h0);
    check("rst_dm_be", {28'h0, dm_be}, 32'h0);
    check("rst_W", W_PC | W_ins | W_alu_res | W_mem_read, 32'h0);
    check("rst_misalign", {31'h0, misalign}, 32'h0);
    $display("reset checked");
    M_ins = 32'h0;
    reset = 1'b0;

    alu_op(32'h3000, 32'h0022_1821, 32'h5);
    alu_op(32'h3004, 32'h0043_2021, 32'hFFFF_0000);
    mem_op(6'h20, 32'h3008, 32'h1003, 32'h0, 32'h80FF_1234, 3, 1'b0, 4'b1111, 32'h0, 32'hFFFF_FF80);
    mem_op(6'h25, 32'h300C, 32'h2002, 32'h0, 32'h9ABC_0000, 0, 1'b0, 4'b1111, 32'h0, 32'h0000_9ABC);
    mem_op(6'h21, 32'h3010, 32'h2002, 32'h0, 32'h9ABC_0000, 1, 1'b0, 4'b1111, 32'h0, 32'hFFFF_9ABC);
    mem_op(6'h21, 32'h3014, 32'h2000, 32'h0, 32'h9ABC_8001, 0, 1'b0, 4'b1111, 32'h0, 32'hFFFF_8001);
    mem_op(6'h25, 32'h3018, 32'h2000, 32'h0, 32'h9ABC_8001, 0, 1'b0, 4'b1111, 32'h0, 32'h0000_8001);
    mem_op(6'h24, 32'h301C, 32'h1001, 32'h0, 32'h80FF_1234, 0, 1'b0, 4'b1111, 32'h0, 32'h0000_0012);
    mem_op(6'h20, 32'h3020, 32'h1000, 32'h0, 32'h80FF_1234, 2, 1'b0, 4'b1111, 32'h0, 32'h0000_0034);
    mem_op(6'h24, 32'h3024, 32'h1003, 32'h0, 32'h80FF_1234, 0, 1'b0, 4'b1111, 32'h0, 32'h0000_0080);
    mem_op(6'h23, 32'h3028, 32'h3004, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 4'b1111, 32'h0, 32'hDEAD_BEEF);
    mem_op(6'h28, 32'h302C, 32'h11, 32'h1234_5678, 32'hFFFF_FFFF, 0, 1'b1, 4'b0010, 32'h7878_7878, 32'h0);
    mem_op(6'h29, 32'h3030, 32'h12, 32'h1234_5678, 32'hFFFF_FFFF, 1, 1'b1, 4'b1100, 32'h5678_5678, 32'h0);
    mem_op(6'h29, 32'h3034, 32'h10, 32'h1234_5678, 32'hFFFF_FFFF, 0, 1'b1, 4'b0011, 32'h5678_5678, 32'h0);
    mem_op(6'h28, 32'h3038, 32'h13, 32'h0000_00A5, 32'h0, 0, 1'b1, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    mem_op(6'h2B, 32'h303C, 32'h20, 32'hCAFE_F00D, 32'h0, 2, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0);
    alu_op(32'h3040, 32'h0085_3021, 32'h77);
    misalign_op(6'h23, 32'h3044, 32'h6);
    misalign_op(6'h29, 32'h3048, 32'h11);
    misalign_op(6'h25, 32'h304C, 32'h3);

    // Reset while a store is outstanding; the ack one cycle later must be ignored
    @(negedge clk);
    M_PC = 32'h3050; M_ins = {6'h2B, 26'h0}; alu_res = 32'h40; reg_rt = 32'h5555_AAAA; dm_ack = 1'b0;
    @(negedge clk);
    check("rstb_busy_req", {31'h0, dm_req}, 32'h1);
    reset = 1'b1;
    #1;
    check("rstb_m_stall", {31'h0, m_stall}, 32'h0);
    @(negedge clk);
    reset = 1'b0; dm_ack = 1'b1;
    M_PC = 32'h0; M_ins = 32'h0; alu_res = 32'h0;
    #1;
    check("rstb_dm_req", {31'h0, dm_req}, 32'h0);
    check("rstb_m_stall_after", {31'h0, m_stall}, 32'h0);
    check("rstb_W_cleared", W_PC | W_ins | W_alu_res | W_mem_read, 32'h0);
    @(negedge clk);
    dm_ack = 1'b0;
    check("rstb_late_ack_req", {31'h0, dm_req}, 32'h0);
    check("rstb_late_ack_W", W_PC | W_ins | W_alu_res | W_mem_read, 32'h0);
    $display("reset during BUSY checked");

    repeat (3) filler();
    check("sb_drained", sb_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; data and address widths SHALL be fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 M_PC, M_ins, alu_res, reg_rt  in  32 each  MEM-stage PC, instruction, ALU result (effective address), forwarded rt (store data).
REQ-005 m_stall  out  1  upstream SHALL hold M_* inputs and not advance while high.
REQ-006 dm_req  out  1  data-memory request; dm_we out 1 write; dm_be out 4 byte enables; dm_addr out 32 word-aligned address; dm_wdata out 32 store data.
REQ-007 dm_rdata  in  32  read word; dm_ack in 1 request complete (valid only while dm_req is high).
REQ-008 W_PC, W_ins, W_alu_res, W_mem_read  out  32 each  registered M/W outputs consumed by the writeback stage.
REQ-009 misalign  out  1  one-cycle pulse, registered, flagging a dropped misaligned access.

Function
REQ-010 Decode SHALL use opcode M_ins[31:26]: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24, sw 0x2B, sh 0x29, sb 0x28; all other opcodes SHALL be non-memory.
REQ-011 FSM states SHALL be IDLE and BUSY.
REQ-012 IDLE with a non-memory instruction: m_stall=0; at the edge, W_* SHALL load M_PC, M_ins, alu_res, and W_mem_read=0. This is 1-cycle latency.
REQ-013 IDLE with an aligned memory instruction: m_stall=1; at the edge, latch op, addr, be, wdata, PC, ins, alu_res; go BUSY; W_* SHALL load a bubble (all four = 0).
REQ-014 BUSY: dm_req=1 with latched dm_we/dm_be/dm_addr/dm_wdata held stable until dm_ack.
REQ-015 BUSY with dm_ack=0: m_stall=1; W_* SHALL load a bubble.
REQ-016 BUSY with dm_ack=1: m_stall=0 combinationally; at the edge, W_* SHALL load the latched PC/ins/alu_res plus the extended load data (0 for stores); go IDLE.
REQ-017 Minimum memory latency: accept at edge N, ack in the first BUSY cycle, W valid after edge N+1.
REQ-018 dm_addr SHALL be {addr[31:2], 2'b00}.
REQ-019 Store byte enables and data:
- sw: be=1111, wdata=rt.
- sh: be=0011 if addr[1]=0 else 1100; wdata={2{rt[15:0]}}.
- sb: be=0001<<addr[1:0]; wdata={4{rt[7:0]}}.
REQ-020 Loads SHALL have dm_we=0 and be=1111.
REQ-021 Load extraction from dm_rdata:
- lb/lbu select byte addr[1:0]; lh/lhu select halfword addr[1].
- lb, lh sign-extend; lbu, lhu zero-extend; lw passes the word.
REQ-022 Misaligned accesses (lw/sw addr[1:0]≠0, lh/lhu/sh addr[0]≠0):
- no request issued, FSM stays IDLE, m_stall=0;
- W_* SHALL load a bubble;
- misalign=1 for the following cycle.
REQ-023 dm_ack outside BUSY SHALL be ignored.
REQ-024 M_* input changes during BUSY SHALL NOT affect the latched request.
REQ-025 A memory instruction arriving in IDLE the cycle after a completion SHALL be accepted normally; back-to-back accesses need no idle gap beyond REQ-013.
REQ-026 dm_req, dm_we, dm_be SHALL be 0 in IDLE.

Reset
REQ-027 Reset SHALL force IDLE and clear dm_req, dm_we, dm_be, misalign, W_PC, W_ins, W_alu_res, W_mem_read, and all latched fields to 0.
REQ-028 Reset during BUSY SHALL abandon the request: dm_req=0 from the next cycle, and an ack in the reset cycle is discarded.
REQ-029 m_stall SHALL be 0 while reset is asserted.

Verification
REQ-030 Stimulus: addu, M_PC=0x3000, alu_res=0x5 -> next cycle W_PC=0x3000, W_alu_res=0x5, W_mem_read=0, m_stall never 1.
REQ-031 Stimulus: lb at addr 0x1003, dm_rdata=0x80FF1234, ack after 3 BUSY cycles ->
- dm_addr=0x1000, be=1111, m_stall high 4 cycles, W bubbles 3 cycles;
- then W_mem_read=0xFFFFFF80.
REQ-032 Stimulus: lhu at addr 0x2002, dm_rdata=0x9ABC0000, immediate ack -> W_mem_read=0x00009ABC one edge after BUSY.
REQ-033 Stimulus: sb at addr 0x11, rt=0x12345678 -> dm_we=1, dm_be=0010, dm_addr=0x10, dm_wdata=0x78787878; sh at addr 0x12 -> dm_be=1100, dm_wdata=0x56785678.
REQ-034 Stimulus: lw at addr 0x6 -> dm_req stays 0, m_stall=0, W bubble, misalign=1 for one cycle.
REQ-035 Stimulus: sw in BUSY, reset pulsed before ack, ack arrives the cycle after reset -> IDLE, dm_req=0, the late ack is ignored, and all W_*=0.
